// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolution controller: func3 codes, FSM encoding, PC step.
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } br_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_br_cond_eval.sv
// Combinational RV32I branch condition evaluator: (func3, A, B) -> {taken, illegal}.
import branch_resolve_ctrl_pkg::*;

module br_cond_eval #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken_c,
    output logic            illegal_c
);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        unique case (func3)
            BR_BEQ:  taken_c = (a == b);
            BR_BNE:  taken_c = (a != b);
            BR_BLT:  taken_c = ($signed(a) <  $signed(b));
            BR_BGE:  taken_c = ($signed(a) >= $signed(b));
            BR_BLTU: taken_c = (a <  b);
            BR_BGEU: taken_c = (a >= b);
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: registers one branch, resolves it, redirects and flushes on mispredict.
// Optional performance counters enabled by defining BR_PERF_CNT_EN.
import branch_resolve_ctrl_pkg::*;

module branch_resolve_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid_i,
    output logic            br_ready_o,
    input  logic [2:0]      br_func3_i,
    input  logic [XLEN-1:0] br_rs1_i,
    input  logic [XLEN-1:0] br_rs2_i,
    input  logic [XLEN-1:0] br_pc_i,
    input  logic [XLEN-1:0] br_imm_i,
    input  logic            br_pred_taken_i,
    input  logic            kill_i,
    output logic            res_valid_o,
    output logic            res_taken_o,
    output logic            illegal_o,
    output logic            misalign_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
`ifdef BR_PERF_CNT_EN
    output logic [31:0]     perf_branches_o,
    output logic [31:0]     perf_mispred_o,
`endif
    output logic            flush_o
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);

    br_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       func3_q;
    logic [XLEN-1:0]  rs1_q, rs2_q, pc_q, imm_q;
    logic             pred_q;

    logic             taken_c, illegal_c;
    logic [XLEN-1:0]  target_c, fallthrough_c;
    logic             misalign_c, mispredict_c, accept_c, result_fire_c;

    logic             res_valid_d, res_taken_d, illegal_d, misalign_d, redirect_d;
    logic             flush_d, ready_d;
    logic [XLEN-1:0]  redirect_pc_d;

    br_cond_eval #(.XLEN(XLEN)) u_cond (
        .func3     (func3_q),
        .a         (rs1_q),
        .b         (rs2_q),
        .taken_c   (taken_c),
        .illegal_c (illegal_c)
    );

    assign target_c      = pc_q + imm_q;
    assign fallthrough_c = pc_q + XLEN'(PC_INC);
    assign misalign_c    = taken_c & (target_c[1:0] != 2'b00);
    assign mispredict_c  = ~misalign_c & (taken_c != pred_q);
    assign accept_c      = (state_q == ST_IDLE) & br_ready_o & br_valid_i & ~kill_i;
    assign result_fire_c = (state_q == ST_EVAL) & ~kill_i;

    // State, operand and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            func3_q       <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            pc_q          <= '0;
            imm_q         <= '0;
            pred_q        <= 1'b0;
            br_ready_o    <= 1'b0;
            res_valid_o   <= 1'b0;
            res_taken_o   <= 1'b0;
            illegal_o     <= 1'b0;
            misalign_o    <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            flush_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            if (accept_c) begin
                func3_q <= br_func3_i;
                rs1_q   <= br_rs1_i;
                rs2_q   <= br_rs2_i;
                pc_q    <= br_pc_i;
                imm_q   <= br_imm_i;
                pred_q  <= br_pred_taken_i;
            end
            br_ready_o    <= ready_d;
            res_valid_o   <= res_valid_d;
            res_taken_o   <= res_taken_d;
            illegal_o     <= illegal_d;
            misalign_o    <= misalign_d;
            redirect_o    <= redirect_d;
            redirect_pc_o <= redirect_pc_d;
            flush_o       <= flush_d;
        end
    end

    // Next-state logic; a kill during EVAL discards the branch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_EVAL;
            ST_EVAL: begin
                if (kill_i) begin
                    state_d = ST_IDLE;
                end else if (mispredict_c) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; status fields hold until the next result
    always_comb begin
        res_valid_d   = result_fire_c;
        res_taken_d   = res_taken_o;
        illegal_d     = illegal_o;
        misalign_d    = misalign_o;
        redirect_d    = result_fire_c & mispredict_c;
        redirect_pc_d = redirect_pc_o;
        flush_d       = (state_d == ST_FLUSH);
        ready_d       = (state_d == ST_IDLE);
        if (result_fire_c) begin
            res_taken_d   = taken_c;
            illegal_d     = illegal_c;
            misalign_d    = misalign_c;
            redirect_pc_d = taken_c ? target_c : fallthrough_c;
        end
    end

`ifdef BR_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches_o <= '0;
            perf_mispred_o  <= '0;
        end else begin
            if (res_valid_d) perf_branches_o <= perf_branches_o + 32'd1;
            if (redirect_d)  perf_mispred_o  <= perf_mispred_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl.
`timescale 1ns/1ps

module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst;
    logic        br_valid_i;
    logic        br_ready_o;
    logic [2:0]  br_func3_i;
    logic [31:0] br_rs1_i, br_rs2_i, br_pc_i, br_imm_i;
    logic        br_pred_taken_i;
    logic        kill_i;
    logic        res_valid_o, res_taken_o, illegal_o, misalign_o, redirect_o, flush_o;
    logic [31:0] redirect_pc_o;
`ifdef BR_PERF_CNT_EN
    logic [31:0] perf_branches_o, perf_mispred_o;
`endif

    int checks   = 0;
    int failures = 0;

    branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .br_valid_i      (br_valid_i),
        .br_ready_o      (br_ready_o),
        .br_func3_i      (br_func3_i),
        .br_rs1_i        (br_rs1_i),
        .br_rs2_i        (br_rs2_i),
        .br_pc_i         (br_pc_i),
        .br_imm_i        (br_imm_i),
        .br_pred_taken_i (br_pred_taken_i),
        .kill_i          (kill_i),
        .res_valid_o     (res_valid_o),
        .res_taken_o     (res_taken_o),
        .illegal_o       (illegal_o),
        .misalign_o      (misalign_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
`ifdef BR_PERF_CNT_EN
        .perf_branches_o (perf_branches_o),
        .perf_mispred_o  (perf_mispred_o),
`endif
        .flush_o         (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) at negedges for the controller to be ready
    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && br_ready_o !== 1'b1; i++) @(negedge clk);
        if (br_ready_o !== 1'b1) check({tag, "_ready_timeout"}, 32'(br_ready_o), 32'd1);
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        br_valid_i      = 1'b1;
        br_func3_i      = f3;
        br_rs1_i        = a;
        br_rs2_i        = b;
        br_pc_i         = pc;
        br_imm_i        = imm;
        br_pred_taken_i = pred;
    endtask

    task automatic run_br(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pred, input logic e_taken, input logic e_ill,
                          input logic e_mis, input logic e_redir, input logic [31:0] e_pc);
        wait_ready(tag);
        drive(f3, a, b, pc, imm, pred);
        @(posedge clk);
        @(negedge clk);
        br_valid_i = 1'b0;
        check({tag, "_eval_ready"}, 32'(br_ready_o), 32'd0);
        check({tag, "_eval_valid"}, 32'(res_valid_o), 32'd0);
        @(negedge clk);
        check({tag, "_valid"},    32'(res_valid_o), 32'd1);
        check({tag, "_taken"},    32'(res_taken_o), 32'(e_taken));
        check({tag, "_illegal"},  32'(illegal_o),   32'(e_ill));
        check({tag, "_misalign"}, 32'(misalign_o),  32'(e_mis));
        check({tag, "_redirect"}, 32'(redirect_o),  32'(e_redir));
        check({tag, "_pc"},       redirect_pc_o,    e_pc);
        check({tag, "_flush"},    32'(flush_o),     32'(e_redir));
        check({tag, "_ready"},    32'(br_ready_o),  32'(!e_redir));
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(res_valid_o), 32'd0);
        check({tag, "_redir_drop"}, 32'(redirect_o),  32'd0);
        if (e_redir) begin
            check({tag, "_flush2"}, 32'(flush_o),    32'd1);
            check({tag, "_ready2"}, 32'(br_ready_o), 32'd0);
            @(negedge clk);
            check({tag, "_flush_end"}, 32'(flush_o),    32'd0);
            check({tag, "_ready_end"}, 32'(br_ready_o), 32'd1);
        end
        check({tag, "_pc_hold"}, redirect_pc_o, e_pc);
    endtask

    initial begin
        rst = 1'b1;
        kill_i = 1'b0;
        drive(3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        br_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready",  32'(br_ready_o),  32'd0);
        check("rst_valid",  32'(res_valid_o), 32'd0);
        check("rst_flush",  32'(flush_o),     32'd0);
        check("rst_redir",  32'(redirect_o),  32'd0);
        check("rst_pc",     redirect_pc_o,    32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(br_ready_o), 32'd1);

        //     tag        f3      rs1           rs2    pc            imm    pred tk il ms rd exp_pc
        run_br("beq_mp",  3'b000, 32'd5,        32'd5, 32'h100,      32'h20, 0, 1, 0, 0, 1, 32'h120);
        run_br("blt",     3'b100, 32'hFFFFFFFF, 32'd1, 32'h100,      32'h20, 1, 1, 0, 0, 0, 32'h120);
        run_br("bltu",    3'b110, 32'hFFFFFFFF, 32'd1, 32'h100,      32'h20, 1, 0, 0, 0, 1, 32'h104);
        run_br("bge_eq",  3'b101, 32'd7,        32'd7, 32'h100,      32'h20, 1, 1, 0, 0, 0, 32'h120);
        run_br("bge_lt",  3'b101, 32'd3,        32'd7, 32'h100,      32'h20, 0, 0, 0, 0, 0, 32'h104);
        run_br("bgeu",    3'b111, 32'h80000000, 32'd1, 32'h100,      32'h20, 1, 1, 0, 0, 0, 32'h120);
        run_br("illegal", 3'b010, 32'd5,        32'd5, 32'h100,      32'h20, 0, 0, 1, 0, 0, 32'h104);
        run_br("wrap",    3'b000, 32'd9,        32'd9, 32'hFFFFFFF0, 32'h20, 0, 1, 0, 0, 1, 32'h10);
        run_br("misalgn", 3'b000, 32'd9,        32'd9, 32'h100,      32'h2,  0, 1, 0, 1, 0, 32'h102);
        run_br("bne",     3'b001, 32'd1,        32'd2, 32'h200,      32'h40, 1, 1, 0, 0, 0, 32'h240);

        // kill in IDLE blocks acceptance
        wait_ready("kill_idle");
        drive(3'b000, 32'd1, 32'd1, 32'h300, 32'h10, 1'b0);
        kill_i = 1'b1;
        @(negedge clk);
        check("kill_idle_ready", 32'(br_ready_o), 32'd1);
        br_valid_i = 1'b0;
        kill_i = 1'b0;
        @(negedge clk);
        check("kill_idle_valid", 32'(res_valid_o), 32'd0);

        // kill during EVAL discards the branch
        wait_ready("kill_eval");
        drive(3'b000, 32'd1, 32'd1, 32'h300, 32'h10, 1'b0);
        @(posedge clk);
        @(negedge clk);
        br_valid_i = 1'b0;
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill_eval_valid", 32'(res_valid_o), 32'd0);
        check("kill_eval_redir", 32'(redirect_o),  32'd0);
        check("kill_eval_flush", 32'(flush_o),     32'd0);
        check("kill_eval_ready", 32'(br_ready_o),  32'd1);
        check("kill_eval_pc",    redirect_pc_o,    32'h240);

`ifdef BR_PERF_CNT_EN
        check("perf_branches", perf_branches_o, 32'd10);
        check("perf_mispred",  perf_mispred_o,  32'd3);
`endif

        // asynchronous reset in the middle of a flush
        wait_ready("rst_flush");
        drive(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        @(posedge clk);
        @(negedge clk);
        br_valid_i = 1'b0;
        @(negedge clk);
        check("rstf_pre_flush", 32'(flush_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstf_flush", 32'(flush_o),     32'd0);
        check("rstf_redir", 32'(redirect_o),  32'd0);
        check("rstf_valid", 32'(res_valid_o), 32'd0);
        check("rstf_ready", 32'(br_ready_o),  32'd0);
        check("rstf_pc",    redirect_pc_o,    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstf_ready_after", 32'(br_ready_o), 32'd1);
        check("rstf_flush_after", 32'(flush_o),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
